// File: rtl/mult_unit_pkg.sv
// Shared definitions for the execute-stage multiplier: state encoding,
// word width and the MIPS funct codes that drive it.
package mult_unit_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_CALC = 2'd1,
    MULT_FIX  = 2'd2
  } mult_state_e;

  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;

endpackage

// File: rtl/mult_if.sv
// Control-unit <-> multiplier bundle: request operands in, HI/LO and status out.
interface mult_if
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) ();

  logic             start_mult;
  logic             mult_sign;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start_mult, mult_sign, src_a, src_b,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start_mult, mult_sign, src_a, src_b,
    output hi, lo, busy, done
  );

endinterface

// File: rtl/mult_unit.sv
// Radix-2 shift-add multiplier: magnitudes are multiplied unsigned over WIDTH
// cycles, then the sign is applied in one fix-up cycle that writes HI/LO.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int CNT_W = 6
) (
  input logic  clk,
  input logic  rst,
  mult_if.slave bus
);

  mult_state_e state_q, state_d;

  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mag_a_q;
  logic [WIDTH-1:0]   acc_hi_q;
  logic [WIDTH-1:0]   acc_lo_q;
  logic               neg_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               load, step, fix, last_iter;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod, result;

  // Operand magnitudes; -(2^(WIDTH-1)) maps to itself, which is the correct
  // unsigned magnitude.
  assign mag_a_in = (bus.mult_sign && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign mag_b_in = (bus.mult_sign && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

  // acc_lo starts as the multiplier and fills with product bits as it shifts.
  assign addend = acc_lo_q[0] ? mag_a_q : '0;
  assign sum    = {1'b0, acc_hi_q} + {1'b0, addend};
  assign prod   = {acc_hi_q, acc_lo_q};
  assign result = neg_q ? (~prod + 1'b1) : prod;

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= MULT_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      MULT_IDLE: begin
        if (bus.start_mult) begin
          load    = 1'b1;
          state_d = MULT_CALC;
        end
      end
      MULT_CALC: begin
        step = 1'b1;
        if (last_iter) state_d = MULT_FIX;
      end
      MULT_FIX: begin
        fix     = 1'b1;
        state_d = MULT_IDLE;
      end
      default: state_d = MULT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      mag_a_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      if (load) begin
        mag_a_q  <= mag_a_in;
        acc_hi_q <= '0;
        acc_lo_q <= mag_b_in;
        neg_q    <= bus.mult_sign & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
        cnt_q    <= '0;
      end else if (step) begin
        // Carry out of the add lands in acc_hi's MSB after the shift.
        acc_hi_q <= sum[WIDTH:1];
        acc_lo_q <= {sum[0], acc_lo_q[WIDTH-1:1]};
        cnt_q    <= cnt_q + CNT_W'(1);
      end
      if (fix) begin
        hi_q <= result[2*WIDTH-1:WIDTH];
        lo_q <= result[WIDTH-1:0];
      end
      done_q <= fix;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q != MULT_IDLE);
  assign bus.done = done_q;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed table, corner sequences and
// random operands against a plain 64-bit arithmetic model.
module tb_mult_unit;
  import mult_unit_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mult_if #(.WIDTH(32)) bus ();

  mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint          sp;
    longint unsigned up;
    if (sgn) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return 64'(sp);
    end
    up = longint'({32'b0, a}) * longint'({32'b0, b});
    return 64'(up);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one multiply, wait for done; returns latency and busy-cycle count.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output int lat, output int nbusy,
                         output logic [31:0] rhi, output logic [31:0] rlo);
    bus.start_mult = 1'b1;
    bus.mult_sign  = sgn;
    bus.src_a      = a;
    bus.src_b      = b;
    @(posedge clk); #1;
    bus.start_mult = 1'b0;
    lat   = 0;
    nbusy = bus.busy ? 1 : 0;
    while (!bus.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy) nbusy++;
    end
    rhi = bus.hi;
    rlo = bus.lo;
  endtask

  vec_t tbl[7];

  initial begin
    int          lat, nbusy, ndone, bad, t1, t2;
    logic [31:0] rhi, rlo, a, b;
    logic [63:0] prev, got;
    logic        sgn;

    tbl[0] = '{32'd3,        32'd5,        1'b0, 32'h00000000, 32'h0000000F};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001};
    tbl[3] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[4] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
    tbl[5] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000000};
    tbl[6] = '{32'h80000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h80000000};

    rst            = 1'b1;
    bus.start_mult = 1'b0;
    bus.mult_sign  = 1'b0;
    bus.src_a      = '0;
    bus.src_b      = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      do_mult(tbl[i].a, tbl[i].b, tbl[i].sgn, lat, nbusy, rhi, rlo);
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'd33);
      chk($sformatf("tbl%0d_busy_cycles", i), 64'(nbusy), 64'd33);
      chk($sformatf("tbl%0d_hi", i), 64'(rhi), 64'(tbl[i].ehi));
      chk($sformatf("tbl%0d_lo", i), 64'(rlo), 64'(tbl[i].elo));
      chk($sformatf("tbl%0d_model", i), {rhi, rlo}, model(tbl[i].a, tbl[i].b, tbl[i].sgn));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_done_falls", i), 64'(bus.done), 64'd0);
    end

    // start_mult while busy is ignored; hi/lo hold until done
    prev = {bus.hi, bus.lo};
    bus.start_mult = 1'b1; bus.mult_sign = 1'b0; bus.src_a = 32'd7; bus.src_b = 32'd6;
    @(posedge clk); #1;
    bus.start_mult = 1'b0;
    ndone = 0; bad = 0; got = '0;
    for (int c = 1; c <= 50; c++) begin
      if (c == 10) begin
        bus.start_mult = 1'b1; bus.src_a = 32'd2; bus.src_b = 32'd2;
      end else begin
        bus.start_mult = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done) begin
        ndone++;
        if (ndone == 1) got = {bus.hi, bus.lo};
      end else if (ndone == 0 && {bus.hi, bus.lo} != prev) begin
        bad++;
      end
    end
    chk("restart_done_count", 64'(ndone), 64'd1);
    chk("restart_result", got, 64'd42);
    chk("restart_hilo_held", 64'(bad), 64'd0);

    // Reset mid-operation discards the partial result
    bus.start_mult = 1'b1; bus.mult_sign = 1'b0; bus.src_a = 32'd7; bus.src_b = 32'd6;
    @(posedge clk); #1;
    bus.start_mult = 1'b0;
    for (int c = 1; c < 15; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("midrst_no_done", 64'(ndone), 64'd0);
    do_mult(32'd2, 32'd3, 1'b0, lat, nbusy, rhi, rlo);
    chk("postrst_latency", 64'(lat), 64'd33);
    chk("postrst_result", {rhi, rlo}, 64'd6);

    // start held high across FIX: next op accepted one idle edge after done
    @(posedge clk); #1;
    bus.start_mult = 1'b1; bus.mult_sign = 1'b1; bus.src_a = 32'hFFFFFFFE; bus.src_b = 32'd3;
    @(posedge clk); #1;
    t1 = 0; t2 = 0;
    for (int c = 1; c <= 100 && t2 == 0; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (t1 == 0) t1 = c;
        else begin
          t2 = c;
          bus.start_mult = 1'b0;
        end
      end
    end
    bus.start_mult = 1'b0;
    chk("held_first_done", 64'(t1), 64'd33);
    chk("held_second_done", 64'(t2), 64'd67);
    chk("held_result", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFA);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
    end

    // Random operands against the model
    for (int i = 0; i < 40; i++) begin
      a   = $urandom;
      b   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: a = 32'h80000000;
        1: b = 32'h0;
        2: a = 32'hFFFFFFFF;
        default: ;
      endcase
      do_mult(a, b, sgn, lat, nbusy, rhi, rlo);
      chk($sformatf("rand%0d_latency", i), 64'(lat), 64'd33);
      chk($sformatf("rand%0d_a%h_b%h_s%0d", i, a, b, sgn), {rhi, rlo}, model(a, b, sgn));
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
